// File: rtl/apb_fifo_pkg.sv
// -----------------------------------------------------------------------------
// apb_fifo_pkg
// Shared definitions for the APB FIFO slave:
//   - APB transfer state enum (IDLE / SETUP / ACCESS)
//   - register offsets, decoded from PADDR[3:2]
//   - CTRL / STATUS bit positions
//   - saturating increment helper for the DROP counter
// -----------------------------------------------------------------------------
package apb_fifo_pkg;

    localparam int DATA_W = 32;
    localparam int DROP_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } apb_state_e;

    // Word offsets (PADDR[3:2])
    localparam logic [1:0] REG_CTRL   = 2'd0;  // 0x0
    localparam logic [1:0] REG_STATUS = 2'd1;  // 0x4
    localparam logic [1:0] REG_DATA   = 2'd2;  // 0x8
    localparam logic [1:0] REG_DROP   = 2'd3;  // 0xC

    // CTRL bits
    localparam int CTRL_EN_BIT    = 0;
    localparam int CTRL_FLUSH_BIT = 1;

    // STATUS bits
    localparam int STAT_EMPTY_BIT = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_COUNT_LSB = 8;
    localparam int STAT_COUNT_W   = 9;   // holds COUNT for DEPTH up to 256

    function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
        return (v == {DROP_W{1'b1}}) ? v : v + DROP_W'(1);
    endfunction

endpackage

// File: rtl/apb_fifo_slave_buf.sv
// -----------------------------------------------------------------------------
// apb_fifo_buf
// Circular-buffer FIFO with wrapping read/write pointers and an occupancy count.
// A push while full is discarded, even when a pop happens in the same cycle.
// Flush zeroes pointers and count and overrides a same-cycle pop.
//
// Ports:
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_push, i_data   push request and data
//   i_pop            pop request (ignored when empty)
//   i_flush          discard all entries
//   o_data           head entry
//   o_full, o_empty  occupancy flags
//   o_count          number of stored entries (clog2(DEPTH)+1 bits)
// -----------------------------------------------------------------------------
module apb_fifo_buf
    import apb_fifo_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_push,
    input  logic [DATA_W-1:0]        i_data,
    input  logic                     i_pop,
    input  logic                     i_flush,
    output logic [DATA_W-1:0]        o_data,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [AW-1:0]     r_wr_ptr;
    logic [AW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_count;

    logic w_full;
    logic w_empty;
    logic w_do_push;
    logic w_do_pop;

    assign w_full    = (r_count == CW'(DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_do_push = i_push & ~w_full;
    assign w_do_pop  = i_pop & ~w_empty;

    // NOTE: storage has no reset; only pointers and count define what is valid,
    // so resetting the array would just cost flops and reset routing.
    always_ff @(posedge i_clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);   // wraps naturally, DEPTH is 2^AW
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_do_push, w_do_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_full  = w_full;
    assign o_empty = w_empty;
    assign o_count = r_count;

endmodule

// File: rtl/apb_fifo_slave.sv
// -----------------------------------------------------------------------------
// apb_fifo_slave
// APB slave with a push-only data register feeding a FIFO that drains through
// a valid/ready stream port.
//
// Register map (PADDR[3:2]):
//   0x0 CTRL   bit0 EN (r/w), bit1 FLUSH (write-1, reads 0)
//   0x4 STATUS bit0 EMPTY, bit1 FULL, bits[16:8] COUNT (read-only)
//   0x8 DATA   write pushes PWDATA, reads 0
//   0xC DROP   8-bit saturating overflow count, any write clears
//
// Ports:
//   PCLK, PRESET                      clock, asynchronous active-low reset
//   PSEL, PENABLE, PWRITE, PADDR,
//   PWDATA, PRDATA, PREADY            APB slave interface
//   out_valid, out_data, out_ready    stream output (head of FIFO)
//
// Build option: define APB_FIFO_WAIT_EN to insert WAIT_CYCLES access-phase wait
// states; without it PREADY completes on the first access cycle.
// -----------------------------------------------------------------------------
module apb_fifo_slave
    import apb_fifo_pkg::*;
#(
    parameter int DEPTH       = 8,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              PCLK,
    input  logic              PRESET,
    input  logic              PSEL,
    input  logic              PENABLE,
    input  logic              PWRITE,
    input  logic [31:0]       PADDR,
    input  logic [31:0]       PWDATA,
    output logic [31:0]       PRDATA,
    output logic              PREADY,
    output logic              out_valid,
    output logic [31:0]       out_data,
    input  logic              out_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    apb_state_e        r_state;
    apb_state_e        w_next_state;
    logic              r_en;
    logic [DROP_W-1:0] r_drop;

    logic              w_pready;
    logic              w_complete;
    logic [1:0]        w_reg_sel;
    logic              w_ctrl_wr;
    logic              w_push;
    logic              w_flush;
    logic              w_drop_clr;
    logic              w_pop;
    logic [DATA_W-1:0] w_head;
    logic              w_full;
    logic              w_empty;
    logic [CW-1:0]     w_count;
    logic [31:0]       w_status;

    // Only PADDR[3:2] selects a register.
    logic w_unused_addr;
    assign w_unused_addr = ^{PADDR[31:4], PADDR[1:0]};
    assign w_reg_sel     = PADDR[3:2];

    // ---------------------------------------------------------------- wait logic
`ifdef APB_FIFO_WAIT_EN
    logic [3:0] r_wait_cnt;

    // Cleared in SETUP, counts ACCESS cycles; ready once it reaches WAIT_CYCLES,
    // giving WAIT_CYCLES+1 access cycles per transfer.
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            r_wait_cnt <= '0;
        end else if (w_next_state == ST_ACCESS) begin
            r_wait_cnt <= r_wait_cnt + 4'd1;
        end else begin
            r_wait_cnt <= '0;
        end
    end

    assign w_pready = PRESET & PSEL & PENABLE & (r_wait_cnt == 4'(WAIT_CYCLES));
`else
    localparam int unused_wait_cycles = WAIT_CYCLES;
    assign w_pready = PRESET & PSEL & PENABLE;
`endif

    // Every register side effect keys off this single completing-cycle strobe.
    assign w_complete = w_pready;
    assign w_ctrl_wr  = w_complete & PWRITE & (w_reg_sel == REG_CTRL);
    assign w_push     = w_complete & PWRITE & (w_reg_sel == REG_DATA);
    assign w_drop_clr = w_complete & PWRITE & (w_reg_sel == REG_DROP);
    assign w_flush    = w_ctrl_wr & PWDATA[CTRL_FLUSH_BIT];

    // --------------------------------------------------------------------- FSM
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // NOTE: every combinational output gets a default first so no path through
    // the case leaves it unassigned (which would infer a latch).
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (PSEL) begin
                    if (!PENABLE)      w_next_state = ST_SETUP;
                    else if (w_pready) w_next_state = ST_IDLE;
                    else               w_next_state = ST_ACCESS;
                end
            end
            ST_SETUP: begin
                // SETUP lasts one cycle; a repeated setup phase restarts it.
                if (!PSEL)             w_next_state = ST_IDLE;
                else if (PENABLE)      w_next_state = w_pready ? ST_IDLE : ST_ACCESS;
            end
            ST_ACCESS: begin
                if (!PSEL || w_pready) w_next_state = ST_IDLE;
                else if (!PENABLE)     w_next_state = ST_SETUP;
            end
            default:                   w_next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        w_status                                       = '0;
        w_status[STAT_EMPTY_BIT]                       = w_empty;
        w_status[STAT_FULL_BIT]                        = w_full;
        w_status[STAT_COUNT_LSB +: STAT_COUNT_W]       = STAT_COUNT_W'(w_count);

        PREADY = w_pready;
        PRDATA = '0;
        if (PRESET && PSEL && PENABLE && !PWRITE) begin
            case (w_reg_sel)
                REG_CTRL:   PRDATA[CTRL_EN_BIT] = r_en;
                REG_STATUS: PRDATA = w_status;
                REG_DROP:   PRDATA[DROP_W-1:0] = r_drop;
                default:    PRDATA = '0;
            endcase
        end
    end

    // --------------------------------------------------------------- registers
    always_ff @(posedge PCLK or negedge PRESET) begin
        if (!PRESET) begin
            r_en   <= 1'b0;
            r_drop <= '0;
        end else begin
            if (w_ctrl_wr) begin
                r_en <= PWDATA[CTRL_EN_BIT];
            end
            if (w_drop_clr) begin
                r_drop <= '0;
            end else if (w_push && w_full) begin
                r_drop <= sat_inc(r_drop);
            end
        end
    end

    // -------------------------------------------------------------------- FIFO
    // EN gates only the stream side; pushes are accepted regardless.
    assign out_valid = r_en & ~w_empty;
    assign out_data  = w_head;
    assign w_pop     = out_valid & out_ready;

    apb_fifo_buf #(
        .DEPTH (DEPTH)
    ) u_buf (
        .i_clk   (PCLK),
        .i_rst_n (PRESET),
        .i_push  (w_push),
        .i_data  (PWDATA),
        .i_pop   (w_pop),
        .i_flush (w_flush),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

endmodule

// File: tb/tb_apb_fifo_slave.sv
// -----------------------------------------------------------------------------
// tb_apb_fifo_slave
// Self-checking bench: APB writes to DATA feed a reference queue (with its own
// full/drop model); a stream monitor pops and compares on each handshake.
// -----------------------------------------------------------------------------
module tb_apb_fifo_slave;

    localparam int DEPTH       = 8;
    localparam int WAIT_CYCLES = 2;
`ifdef APB_FIFO_WAIT_EN
    localparam int EXP_ACC = WAIT_CYCLES + 1;
`else
    localparam int EXP_ACC = 1;
`endif

    logic        PCLK;
    logic        PRESET;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PADDR;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready;

    int          n_checks = 0;
    int          n_errors = 0;
    int          pops     = 0;
    int          model_drop = 0;
    logic [31:0] sb_q [$];

    apb_fifo_slave #(
        .DEPTH       (DEPTH),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) dut (
        .PCLK      (PCLK),
        .PRESET    (PRESET),
        .PSEL      (PSEL),
        .PENABLE   (PENABLE),
        .PWRITE    (PWRITE),
        .PADDR     (PADDR),
        .PWDATA    (PWDATA),
        .PRDATA    (PRDATA),
        .PREADY    (PREADY),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Reference model of a completed write.
    task automatic model_write(input logic [31:0] addr, input logic [31:0] data);
        case (addr[3:2])
            2'd0: if (data[1]) sb_q.delete();
            2'd2: begin
                if (sb_q.size() == DEPTH) begin
                    if (model_drop < 255) model_drop++;
                end else begin
                    sb_q.push_back(data);
                end
            end
            2'd3: model_drop = 0;
            default: ;
        endcase
    endtask

    task automatic apb_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input bit ready_on_done, output logic [31:0] rdata, output int acc);
        bit done;
        acc   = 0;
        rdata = '0;
        done  = 1'b0;
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = wr; PADDR = addr; PWDATA = wdata;
        @(negedge PCLK);
        check("setup_pready", {31'b0, PREADY}, 32'd0);
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        for (int i = 0; i < 32 && !done; i++) begin
            @(negedge PCLK);
            acc++;
            if (PREADY === 1'b1) begin
                done  = 1'b1;
                rdata = PRDATA;
                if (wr) begin
                    check("wr_prdata", PRDATA, 32'd0);
                    model_write(addr, wdata);
                end
                if (ready_on_done) out_ready = 1'b1;
            end
        end
        if (!done) check("pready_timeout", 32'd0, 32'd1);
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        if (ready_on_done) out_ready = 1'b0;
    endtask

    task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
        logic [31:0] rd;
        int          acc;
        apb_xfer(1'b1, addr, data, 1'b0, rd, acc);
    endtask

    task automatic check_read(input string tag, input logic [31:0] addr, input logic [31:0] exp);
        logic [31:0] rd;
        int          acc;
        apb_xfer(1'b0, addr, 32'd0, 1'b0, rd, acc);
        check(tag, rd, exp);
    endtask

    // Stream monitor: sample the handshake mid-cycle, retire it at the edge.
    initial begin : stream_mon
        logic [31:0] d;
        forever begin
            @(negedge PCLK); #1;
            if (PRESET === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
                d = out_data;
                @(posedge PCLK);
                if (sb_q.size() == 0) check("unexpected_pop", 32'd1, 32'd0);
                else                  check("out_data", d, sb_q.pop_front());
                pops++;
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin : main
        logic [31:0] rd;
        int          acc;
        int          p0;

        PRESET = 1'b0; PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        PADDR = '0; PWDATA = '0; out_ready = 1'b0;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        check("rst_pready",    {31'b0, PREADY},    32'd0);
        check("rst_prdata",    PRDATA,             32'd0);
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        @(posedge PCLK); #1;
        PRESET = 1'b1;

        check_read("status_reset", 32'h0000_0004, 32'h0000_0001);
        check_read("drop_reset",   32'h0000_000C, 32'h0000_0000);

        // Three pushes with EN=0, then drain.
        apb_xfer(1'b1, 32'h8, 32'hA5A5_0001, 1'b0, rd, acc);
        check("access_cycles", acc, EXP_ACC);
        apb_write(32'h8, 32'hA5A5_0002);
        apb_write(32'h8, 32'hA5A5_0003);
        check_read("status_cnt3", 32'hABCD_0004, 32'h0000_0300);
        check("out_valid_en0", {31'b0, out_valid}, 32'd0);
        out_ready = 1'b1;
        p0 = pops;
        apb_write(32'h0, 32'h1);
        repeat (3) @(posedge PCLK);
        #1;
        check("drain_pops", pops - p0, 32'd3);
        check("out_valid_drained", {31'b0, out_valid}, 32'd0);
        out_ready = 1'b0;
        check_read("status_drained", 32'h4, 32'h0000_0001);

        // Overfill with EN=0.
        apb_write(32'h0, 32'h0);
        for (int i = 0; i < 10; i++) apb_write(32'h8, 32'hC0DE_0000 + i);
        check_read("status_full", 32'h4, 32'h0000_0802);
        check_read("drop_2",      32'hC, 32'd2);
        apb_write(32'hC, 32'h1234_5678);
        check_read("drop_cleared", 32'hC, 32'd0);

        // Full, EN=1, pop coincides with the push completion: push still dropped.
        apb_write(32'h0, 32'h1);
        check("out_valid_full", {31'b0, out_valid}, 32'd1);
        check("head_full",      out_data, 32'hC0DE_0000);
        apb_xfer(1'b1, 32'h8, 32'hDEAD_0001, 1'b1, rd, acc);
        check_read("status_cnt7", 32'h4, 32'h0000_0700);
        check_read("drop_1",      32'hC, model_drop);
        check_read("ctrl_en1",    32'h0, 32'h1);
        check_read("data_reads0", 32'hFFFF_FF08, 32'h0);

        // Flush with EN cleared.
        apb_write(32'h0, 32'h2);
        check_read("status_flushed", 32'h4, 32'h0000_0001);
        check_read("ctrl_en0",       32'h0, 32'h0);

        // Reset asserted during the access phase of a DATA write.
        apb_write(32'h8, 32'h1111_0001);
        apb_write(32'h8, 32'h1111_0002);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PWRITE = 1'b1; PADDR = 32'h8; PWDATA = 32'h2222_0000;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        @(negedge PCLK);
        PRESET = 1'b0;
        #1;
        check("abort_pready", {31'b0, PREADY}, 32'd0);
        sb_q.delete();
        model_drop = 0;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
        @(posedge PCLK); #1;
        PRESET = 1'b1;
        check_read("status_abort", 32'h4, 32'h0000_0001);
        check_read("drop_abort",   32'hC, 32'd0);

        // FLUSH and EN together with four entries.
        for (int i = 0; i < 4; i++) apb_write(32'h8, 32'h3333_0000 + i);
        check_read("status_cnt4", 32'h4, 32'h0000_0400);
        apb_write(32'h0, 32'h3);
        check("out_valid_post_flush", {31'b0, out_valid}, 32'd0);
        check_read("status_flush_en", 32'h4, 32'h0000_0001);
        check_read("ctrl_flush_en",   32'h0, 32'h1);

        // DROP saturation (out_ready low, nothing drains).
        for (int i = 0; i < DEPTH + 260; i++) apb_write(32'h8, 32'h4444_0000 + i);
        check_read("drop_saturated", 32'hC, 32'd255);
        check_read("status_sat",     32'h4, 32'h0000_0802);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
